// File: rtl/tlm_stream_pkg.sv
// tlm_stream_pkg: shared state type, defaults and counter-width helper for the item streamer
package tlm_stream_pkg;
    typedef enum logic {IDLE, XMIT} state_t;
    localparam int DEF_NUM        = 100;
    localparam int DEF_ITEM_WIDTH = 8;
    localparam int DEF_CH_NUM     = 2;
    function automatic int cnt_width(input int num);
        return $clog2(num + 1);
    endfunction
endpackage

// File: rtl/tlm_item_select.sv
// tlm_item_select: picks item idx (CH_NUM operands) out of a packed batch buffer
module tlm_item_select
    import tlm_stream_pkg::*;
#(
    parameter int NUM        = DEF_NUM,
    parameter int ITEM_WIDTH = DEF_ITEM_WIDTH,
    parameter int CH_NUM     = DEF_CH_NUM,
    parameter int CNT_W      = cnt_width(NUM)
) (
    input  logic [NUM*CH_NUM*ITEM_WIDTH-1:0] batch,
    input  logic [CNT_W-1:0]                 idx,
    output logic [CH_NUM*ITEM_WIDTH-1:0]     item
);
    localparam int W  = CH_NUM * ITEM_WIDTH;
    localparam int IW = CNT_W + $clog2(CH_NUM) + 1;
    localparam int SW = IW + $clog2(ITEM_WIDTH) + 1;
    logic [IW-1:0] base;
    // operand index of channel 0, widened so no product bits are lost; an idx past the batch yields 0
    always_comb begin
        base = IW'(idx) * IW'(CH_NUM);
        item = W'(batch >> (SW'(base) * SW'(ITEM_WIDTH)));
    end
endmodule

// File: rtl/tlm_stream_xmit.sv
// tlm_stream_xmit: captures a batch of items and streams them one per beat over valid/ready
module tlm_stream_xmit
    import tlm_stream_pkg::*;
#(
    parameter int NUM        = DEF_NUM,
    parameter int ITEM_WIDTH = DEF_ITEM_WIDTH,
    parameter int CH_NUM     = DEF_CH_NUM,
    parameter int CNT_W      = cnt_width(NUM)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             load_i,
    input  logic [NUM*CH_NUM*ITEM_WIDTH-1:0] payload_i,
    input  logic [CNT_W-1:0]                 item_num_i,
    output logic                             ready_o,
    output logic                             busy_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [CH_NUM*ITEM_WIDTH-1:0]     out_data_o,
    output logic                             out_last_o,
    output logic                             done_o,
    output logic [CNT_W-1:0]                 beat_cnt_o
);
    localparam int W  = CH_NUM * ITEM_WIDTH;
    localparam int PW = NUM * W;
    state_t           state;
    logic [PW-1:0]    buf_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] nxt;
    logic [W-1:0]     item_nxt;
    assign ready_o = (state == IDLE);
    assign busy_o  = ~ready_o;
    assign n_in    = (item_num_i > CNT_W'(NUM)) ? CNT_W'(NUM) : item_num_i;
    assign nxt     = beat_cnt_o + CNT_W'(1);
    tlm_item_select #(
        .NUM       (NUM),
        .ITEM_WIDTH(ITEM_WIDTH),
        .CH_NUM    (CH_NUM),
        .CNT_W     (CNT_W)
    ) u_sel (
        .batch(buf_q),
        .idx  (nxt),
        .item (item_nxt)
    );
    // batch FSM: load captures the batch and presents item 0; each accepted beat preloads the following item
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            buf_q       <= '0;
            n_q         <= '0;
            beat_cnt_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (load_i) begin
                    buf_q      <= payload_i;
                    n_q        <= n_in;
                    beat_cnt_o <= '0;
                    if (n_in != '0) begin
                        state       <= XMIT;
                        out_valid_o <= 1'b1;
                        out_last_o  <= (n_in == CNT_W'(1));
                        out_data_o  <= payload_i[W-1:0];
                    end else begin
                        done_o <= 1'b1;
                    end
                end
            end else if (out_ready_i) begin
                beat_cnt_o <= nxt;
                if (out_last_o) begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                    out_data_o  <= '0;
                    done_o      <= 1'b1;
                end else begin
                    out_data_o <= item_nxt;
                    out_last_o <= (nxt == n_q - CNT_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_tlm_stream_xmit.sv
// tb_tlm_stream_xmit: randomized and directed checks of the item streamer against a batch-level model
module tb_tlm_stream_xmit;
    localparam int NUM = 4;
    localparam int IWD = 8;
    localparam int CH  = 2;
    localparam int CW  = 3;
    localparam int DW  = CH * IWD;
    localparam int PW  = NUM * DW;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          load_i = 1'b0;
    logic [PW-1:0] payload_i = '0;
    logic [CW-1:0] item_num_i = '0;
    logic          ready_o, busy_o, out_valid_o, out_last_o, done_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] beat_cnt_o;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    int            got_cyc[$];
    int            done_cnt, done_at, stall_err;
    bit            timeout;

    tlm_stream_xmit #(.NUM(NUM), .ITEM_WIDTH(IWD), .CH_NUM(CH)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load_i),
        .payload_i  (payload_i),
        .item_num_i (item_num_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] model_item(input logic [PW-1:0] p, input int k);
        return p[k*DW +: DW];
    endfunction

    function automatic int model_n(input int num);
        return (num > NUM) ? NUM : num;
    endfunction

    function automatic logic [PW-1:0] byte_ramp(input logic [7:0] start);
        logic [PW-1:0] p;
        for (int j = 0; j < PW/8; j++) p[j*8 +: 8] = start + 8'(j);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_load(input logic [PW-1:0] p, input int num);
        load_i     = 1'b1;
        payload_i  = p;
        item_num_i = CW'(num);
        tick();
        load_i = 1'b0;
    endtask

    task automatic collect(input int mode);
        logic pv, pr, pl;
        logic [DW-1:0] pd;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0; done_at = -1; stall_err = 0; timeout = 1;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            out_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (pv && !pr && (!out_valid_o || out_data_o !== pd || out_last_o !== pl)) stall_err++;
            if (done_o) begin
                done_cnt++;
                done_at = cyc;
                timeout = 0;
                break;
            end
            if (out_valid_o && out_ready_i) begin
                got_data.push_back(out_data_o);
                got_last.push_back(out_last_o);
                got_cyc.push_back(cyc);
            end
            pv = out_valid_o; pr = out_ready_i; pd = out_data_o; pl = out_last_o;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        checks++; if ({ready_o, busy_o, out_valid_o, out_last_o, done_o} !== 5'b10000) $display("FAIL reset_flags: got %b expected 10000", {ready_o, busy_o, out_valid_o, out_last_o, done_o}); else passed++;
        checks++; if (beat_cnt_o !== '0) $display("FAIL reset_cnt: got %0d expected 0", beat_cnt_o); else passed++;
        checks++; if (out_data_o !== '0) $display("FAIL reset_data: got %h expected 0", out_data_o); else passed++;
    endtask

    task automatic test_basic();
        logic [PW-1:0] p = byte_ramp(8'h01);
        drive_load(p, 4);
        collect(0);
        checks++; if (timeout !== 1'b0) $display("FAIL basic_timeout: got %0d expected 0", timeout); else passed++;
        checks++; if (got_data.size() !== 4) $display("FAIL basic_beats: got %0d expected 4", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++; if (got_data[i] !== model_item(p, i)) $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], model_item(p, i)); else passed++;
            checks++; if (got_last[i] !== (i == 3)) $display("FAIL basic_last[%0d]: got %0d expected %0d", i, got_last[i], i == 3); else passed++;
            checks++; if (got_cyc[i] !== i) $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], i); else passed++;
        end
        checks++; if (done_at !== 4) $display("FAIL basic_done_at: got %0d expected 4", done_at); else passed++;
        checks++; if (beat_cnt_o !== CW'(4)) $display("FAIL basic_cnt: got %0d expected 4", beat_cnt_o); else passed++;
        tick();
        checks++; if ({done_o, out_valid_o, ready_o} !== 3'b001) $display("FAIL basic_after_done: got %b expected 001", {done_o, out_valid_o, ready_o}); else passed++;
        checks++; if (beat_cnt_o !== CW'(4)) $display("FAIL basic_cnt_hold: got %0d expected 4", beat_cnt_o); else passed++;
    endtask

    task automatic test_stall();
        logic [PW-1:0] p = byte_ramp(8'h01);
        drive_load(p, 4);
        collect(1);
        checks++; if (got_data.size() !== 4) $display("FAIL stall_beats: got %0d expected 4", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++; if (got_data[i] !== model_item(p, i)) $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i], model_item(p, i)); else passed++;
        end
        checks++; if (stall_err !== 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); else passed++;
        checks++; if (beat_cnt_o !== CW'(4)) $display("FAIL stall_cnt: got %0d expected 4", beat_cnt_o); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL stall_timeout: got %0d expected 0", timeout); else passed++;
    endtask

    task automatic test_zero();
        out_ready_i = 1'b1;
        drive_load(byte_ramp(8'h30), 0);
        checks++; if ({done_o, out_valid_o, ready_o} !== 3'b101) $display("FAIL zero_done: got %b expected 101", {done_o, out_valid_o, ready_o}); else passed++;
        tick();
        checks++; if ({done_o, out_valid_o, ready_o} !== 3'b001) $display("FAIL zero_after: got %b expected 001", {done_o, out_valid_o, ready_o}); else passed++;
    endtask

    task automatic test_clamp();
        logic [PW-1:0] p = byte_ramp(8'h51);
        drive_load(p, 7);
        collect(0);
        checks++; if (got_data.size() !== 4) $display("FAIL clamp_beats: got %0d expected 4", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++; if (got_data[i] !== model_item(p, i)) $display("FAIL clamp_data[%0d]: got %h expected %h", i, got_data[i], model_item(p, i)); else passed++;
            checks++; if (got_last[i] !== (i == 3)) $display("FAIL clamp_last[%0d]: got %0d expected %0d", i, got_last[i], i == 3); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p = byte_ramp(8'h01);
        logic [PW-1:0] q = byte_ramp(8'hA0);
        out_ready_i = 1'b0;
        drive_load(p, 4);
        tick();
        drive_load({$urandom, $urandom}, 1);
        tick();
        checks++; if (beat_cnt_o !== '0) $display("FAIL busy_load_cnt: got %0d expected 0", beat_cnt_o); else passed++;
        collect(0);
        checks++; if (got_data.size() !== 4) $display("FAIL busy_load_beats: got %0d expected 4", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++; if (got_data[i] !== model_item(p, i)) $display("FAIL busy_load_data[%0d]: got %h expected %h", i, got_data[i], model_item(p, i)); else passed++;
        end
        checks++; if (ready_o !== 1'b1) $display("FAIL b2b_ready_in_done: got %0d expected 1", ready_o); else passed++;
        out_ready_i = 1'b0;
        drive_load(q, 4);
        checks++; if ({out_valid_o, out_data_o} !== {1'b1, 16'hA1A0}) $display("FAIL b2b_first: got %b/%h expected 1/a1a0", out_valid_o, out_data_o); else passed++;
        collect(0);
        checks++; if (got_data.size() !== 4) $display("FAIL b2b_beats: got %0d expected 4", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++; if (got_data[i] !== model_item(q, i)) $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_data[i], model_item(q, i)); else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        out_ready_i = 1'b1;
        drive_load(byte_ramp(8'h11), 4);
        tick();
        tick();
        checks++; if (beat_cnt_o !== CW'(2)) $display("FAIL midrst_pre_cnt: got %0d expected 2", beat_cnt_o); else passed++;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++; if ({ready_o, busy_o, out_valid_o, out_last_o, done_o} !== 5'b10000) $display("FAIL midrst_flags: got %b expected 10000", {ready_o, busy_o, out_valid_o, out_last_o, done_o}); else passed++;
        checks++; if ({beat_cnt_o, out_data_o} !== '0) $display("FAIL midrst_cnt_data: got %0d/%h expected 0/0", beat_cnt_o, out_data_o); else passed++;
        for (int i = 0; i < 6; i++) begin
            if (done_o || out_valid_o) dones++;
            tick();
        end
        checks++; if (dones !== 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones); else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [PW-1:0] p = {$urandom, $urandom};
            int num = $urandom_range(0, 7);
            int n = model_n(num);
            drive_load(p, num);
            collect((it % 2 == 0) ? 2 : 1);
            checks++; if (got_data.size() !== n) $display("FAIL rand%0d_beats: got %0d expected %0d", it, got_data.size(), n); else passed++;
            for (int i = 0; i < got_data.size() && i < n; i++) begin
                checks++; if ({got_last[i], got_data[i]} !== {i == n - 1, model_item(p, i)}) $display("FAIL rand%0d_item[%0d]: got %0d/%h expected %0d/%h", it, i, got_last[i], got_data[i], i == n - 1, model_item(p, i)); else passed++;
            end
            checks++; if ({timeout, stall_err} !== 33'd0) $display("FAIL rand%0d_done_stall: got timeout=%0d stall=%0d expected 0/0", it, timeout, stall_err); else passed++;
            checks++; if (beat_cnt_o !== CW'(n)) $display("FAIL rand%0d_cnt: got %0d expected %0d", it, beat_cnt_o, n); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_clamp();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tlm_stream_xmit.md
Name: tlm_stream_xmit

Overview:
- Synthesisable, parametrised successor to the testbench-side pair-streaming loop.
- Captures one batch of up to NUM items, each of CH_NUM operands of ITEM_WIDTH bits, from a packed payload vector. Typically the vector is filled by the DPI gen_tlm_data call or by a host model.
- Streams the batch one item per beat to the DUT-facing side under a valid/ready handshake. Adds runtime item count, back-pressure, last-beat marking and a completion pulse.
- Sits between the stimulus generator and the bfm. Replaces the ad-hoc xmit_en toggling.

Parameters:
- NUM, 100, maximum items per batch (must be at least 1)
- ITEM_WIDTH, 8, bits per operand
- CH_NUM, 2, operands per item (output channels per beat)
- CNT_W, $clog2(NUM+1), width of item counters (derived; do not override)

Ports:
- clk_i  in  1  single clock; all logic is posedge.
- reset_i  in  1  synchronous, active-high reset.
- load_i  in  1  one-cycle pulse: capture payload_i and item_num_i. Honoured only when ready_o=1.
- payload_i  in  NUM*CH_NUM*ITEM_WIDTH  packed batch. Operand c of item k is at bits [(k*CH_NUM+c)*ITEM_WIDTH +: ITEM_WIDTH].
- item_num_i  in  CNT_W  items to send in this batch.
- ready_o  out  1  block is idle and accepts load_i.
- busy_o  out  1  batch in progress (equals ~ready_o).
- out_valid_o  out  1  out_data_o holds a valid item.
- out_ready_i  in  1  sink accepts the current item.
- out_data_o  out  CH_NUM*ITEM_WIDTH  current item. Channel c is at [c*ITEM_WIDTH +: ITEM_WIDTH].
- out_last_o  out  1  current item is the final item of the batch.
- done_o  out  1  one-cycle pulse when a batch completes.
- beat_cnt_o  out  CNT_W  number of items already accepted in this batch.

Behaviour:
- Reset (sampled at posedge): state=IDLE; ready_o=1, busy_o=0, out_valid_o=0, out_last_o=0, done_o=0, beat_cnt_o=0, out_data_o=0. The payload register is cleared to 0.
- Mid-batch reset: the batch is aborted and discarded. No done_o pulse is produced.
- States: IDLE and XMIT.
- IDLE with load_i=1:
  - Register payload_i into the internal buffer.
  - Set n = min(item_num_i, NUM). Values above NUM clamp to NUM.
  - If n>0, go to XMIT. out_valid_o is high in the cycle after the load edge (1-cycle latency).
  - If n=0, stay in IDLE and pulse done_o in the next cycle. No beats are sent.
- XMIT:
  - out_valid_o=1 continuously.
  - out_data_o = buffer item at index idx, where idx=beat_cnt_o.
  - out_last_o = (idx == n-1).
- Handshake: a beat transfers on a posedge where out_valid_o and out_ready_i are both 1.
  - On each beat, beat_cnt_o increments.
  - While out_ready_i=0, out_data_o and out_last_o are held stable and valid stays asserted.
  - out_valid_o never depends combinationally on out_ready_i.
- Last beat: a beat with out_last_o=1 moves the block to IDLE. In the next cycle:
  - out_valid_o=0, out_last_o=0, ready_o=1, done_o=1 for one cycle.
  - beat_cnt_o holds n until the next load or reset.
- load_i while busy: ignored. It has no effect on the buffer, n or the count.
- load_i in the same cycle as done_o=1: accepted, because ready_o is already 1. Back-to-back batches therefore have exactly one idle cycle between the last beat and the first beat of the next batch.
- Outputs: all outputs are registered, except ready_o and busy_o, which decode the state register.
- Widths: the index multiply is done at CNT_W+$clog2(CH_NUM)+1 bits, so there is no truncation for any NUM.

Decomposition:
- Package tlm_stream_pkg holds:
  - the state enum (IDLE, XMIT);
  - the function computing CNT_W;
  - the default NUM, ITEM_WIDTH and CH_NUM constants shared with wrapper and bfm.
- One sub-module, tlm_item_select: a combinational mux from buffer and idx to the CH_NUM*ITEM_WIDTH item, parametrised identically.
- The top module keeps the FSM, the counters and the output registers.

Test Plan (NUM=4, CH_NUM=2, ITEM_WIDTH=8):
- Load bytes 0x01..0x08, item_num=4, out_ready_i tied 1: beats out_data={ch1,ch0} = 0x0201, 0x0403, 0x0605, 0x0807 on 4 consecutive cycles starting 1 cycle after load. out_last_o only on 0x0807. done_o pulses once, one cycle later.
- Same load, out_ready_i toggled 1,0,0,1,...: each item is held stable while stalled. There are exactly 4 beats, in order, and beat_cnt_o ends at 4.
- item_num=0: no out_valid_o. done_o pulses in the cycle after load. ready_o stays 1.
- item_num=7 (greater than NUM): clamps to 4 beats, out_last_o on the 4th beat.
- load_i pulsed during XMIT with new data: ignored, and the original 4 items are sent. Then reload with 0xA0..0xA7 in the done_o cycle: the next batch starts one cycle later with 0xA1A0.
- reset_i asserted after 2 beats: outputs return to reset values the next cycle. No done_o pulse; ready_o=1 and beat_cnt_o=0.
